// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: memory read channel and fetch-queue push channel of the fetch sequencer.
//   mem_req/mem_addr   request side, driven by the sequencer
//   mem_ack            memory accepts the current request (valid with mem_req)
//   mem_rvalid/rdata   in-order read responses
//   q_count            fetch queue occupancy
//   q_push/q_push_value/q_flush   queue write and flush strobes
interface fetch_ctrl_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;

    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] q_count;
    logic          q_push;
    logic [DW-1:0] q_push_value;
    logic          q_flush;

    // Sequencer side
    modport master (
        output mem_req, mem_addr, q_push, q_push_value, q_flush,
        input  mem_ack, mem_rvalid, mem_rdata, q_count
    );

    // Memory / queue side
    modport slave (
        input  mem_req, mem_addr, q_push, q_push_value, q_flush,
        output mem_ack, mem_rvalid, mem_rdata, q_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer between instruction memory and the fetch queue.
//   Owns the fetch PC, only requests reads that are guaranteed a queue slot,
//   pushes returned words in order and, on a branch redirect, flushes the queue
//   and discards the responses of reads that were already in flight.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   i_start           leave IDLE and begin fetching
//   i_halt            level gate on issuing new reads
//   i_redirect(_pc)   one-cycle branch redirect and its target
//   o_fetch_pc        next address to be requested
//   bus               memory request/response and queue push/flush (master side)
module fetch_ctrl #(
    parameter int unsigned QDEPTH       = 6,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [15:0] RESET_PC     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_halt,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic [15:0] o_fetch_pc,
    fetch_ctrl_if.master bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mem_req;
    logic [AW-1:0] r_mem_addr;
    logic [AW-1:0] r_fetch_pc;
    logic          r_q_push;
    logic [DW-1:0] r_q_push_value;
    logic          r_q_flush;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;

    logic          w_redir;
    logic          w_ack;
    logic          w_drop;
    logic          w_take;
    logic          w_issue;
    logic [SW-1:0] w_occ;
    logic [CW-1:0] w_inflight_nxt;
    logic [CW-1:0] w_drop_cnt_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic          w_mem_req_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic          w_q_push_nxt;
    logic [DW-1:0] w_q_push_value_nxt;
    logic          w_q_flush_nxt;

    // Bookkeeping shared by the FSM and the output registers
    always_comb begin : track_comb
        w_redir = i_redirect && (r_state != S_IDLE);
        w_ack   = r_mem_req && bus.mem_ack;
        // A response arriving with a redirect is stale as well
        w_drop  = bus.mem_rvalid && (w_redir || (r_drop_cnt != '0));
        w_take  = bus.mem_rvalid && !w_drop;
        // inflight covers the word held in the push register until it is pushed
        w_inflight_nxt = r_inflight + CW'(w_ack) - CW'(r_q_push) - CW'(w_drop);

        w_drop_cnt_nxt = r_drop_cnt;
        if (w_redir) begin
            w_drop_cnt_nxt = w_inflight_nxt;
        end else if (w_drop) begin
            w_drop_cnt_nxt = r_drop_cnt - CW'(1);
        end

        w_pc_nxt = r_fetch_pc;
        if (w_redir) begin
            w_pc_nxt = i_redirect_pc;
        end else if (w_ack) begin
            w_pc_nxt = r_fetch_pc + AW'(1);
        end

        // Slots already spoken for: queued words plus every accepted read, this cycle's ack included
        w_occ   = SW'(bus.q_count) + SW'(r_inflight) + SW'(w_ack);
        w_issue = (r_state == S_RUN) && !i_halt && !i_redirect &&
                  (w_occ < SW'(QDEPTH)) && (w_inflight_nxt < CW'(MAX_INFLIGHT));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin : state_reg
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: stay in DRAIN while stale responses are still owed
    always_comb begin : next_state_comb
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:         if (i_start) w_state_nxt = S_RUN;
            S_RUN, S_DRAIN: w_state_nxt = (w_drop_cnt_nxt != '0) ? S_DRAIN : S_RUN;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin : output_comb
        w_mem_req_nxt      = w_issue;
        w_mem_addr_nxt     = w_pc_nxt;
        w_q_push_nxt       = w_take;
        w_q_push_value_nxt = r_q_push_value;
        w_q_flush_nxt      = w_redir;
        if (w_take) begin
            w_q_push_value_nxt = bus.mem_rdata;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge reset) begin : out_reg
        if (reset) begin
            r_mem_req      <= 1'b0;
            r_mem_addr     <= RESET_PC;
            r_fetch_pc     <= RESET_PC;
            r_q_push       <= 1'b0;
            r_q_push_value <= '0;
            r_q_flush      <= 1'b0;
            r_inflight     <= '0;
            r_drop_cnt     <= '0;
        end else begin
            r_mem_req      <= w_mem_req_nxt;
            r_mem_addr     <= w_mem_addr_nxt;
            r_fetch_pc     <= w_pc_nxt;
            r_q_push       <= w_q_push_nxt;
            r_q_push_value <= w_q_push_value_nxt;
            r_q_flush      <= w_q_flush_nxt;
            r_inflight     <= w_inflight_nxt;
            r_drop_cnt     <= w_drop_cnt_nxt;
        end
    end

    assign bus.mem_req      = r_mem_req;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.q_push       = r_q_push;
    assign bus.q_push_value = r_q_push_value;
    assign bus.q_flush      = r_q_flush;
    assign o_fetch_pc       = r_fetch_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a latency-programmable
// in-order memory model and a counting fetch-queue model.
module tb_fetch_ctrl;
    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] fetch_pc;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .QDEPTH(6),
        .MAX_INFLIGHT(2),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_start(start),
        .i_halt(halt),
        .i_redirect(redirect),
        .i_redirect_pc(redirect_pc),
        .o_fetch_pc(fetch_pc),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;

    rd_t         pend[$];
    logic [15:0] plog[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          qcnt = 0;
    int          nack = 0;
    int          nrv = 0;
    int          max_out = 0;
    int          nflush = 0;
    int          lat = 2;
    logic        ack_en = 1'b1;
    logic        pop_en = 1'b0;

    function automatic logic [15:0] wdata(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: apply queue effects of the edge, then drive memory for the new cycle
    task automatic tick();
        logic        pp;
        logic        pf;
        logic [15:0] pv;
        rd_t         r;
        pp = bus.q_push;
        pf = bus.q_flush;
        pv = bus.q_push_value;
        @(posedge clk);
        #1;
        cyc++;
        if (pf) begin
            qcnt = 0;
            nflush++;
        end else if (pp) begin
            plog.push_back(pv);
            qcnt++;
        end
        if (pop_en && qcnt > 0) qcnt--;
        bus.q_count = 3'(qcnt);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = wdata(r.addr);
            nrv++;
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 16'hBEEF;
        end
        bus.mem_ack = ack_en;
        if (bus.mem_req && bus.mem_ack) begin
            r.addr = bus.mem_addr;
            r.due  = cyc + lat;
            pend.push_back(r);
            nack++;
        end
        if (nack - nrv > max_out) max_out = nack - nrv;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.q_count = 3'd0;
        pend.delete();
        plog.delete();
        qcnt = 0; nack = 0; nrv = 0; max_out = 0; nflush = 0;
        lat = 2; ack_en = 1'b1; pop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : main
        logic found;
        int   n0;
        int   req_seen;

        // 1: fill the queue with no pops, latency 2
        do_reset();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_fetch_pc", fetch_pc, 16'h0000);
        chk("rst_q_push", bus.q_push, 1'b0);
        chk("rst_q_flush", bus.q_flush, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_req_c1", bus.mem_req, 1'b0);
        tick();
        chk("t1_req_c2", bus.mem_req, 1'b1);
        chk("t1_addr_c2", bus.mem_addr, 16'h0000);
        tick();
        chk("t1_req_c3", bus.mem_req, 1'b1);
        chk("t1_addr_c3", bus.mem_addr, 16'h0001);
        chk("t1_pc_c3", fetch_pc, 16'h0001);
        tick();
        chk("t1_req_c4", bus.mem_req, 1'b0);
        chk("t1_pc_c4", fetch_pc, 16'h0002);
        repeat (40) tick();
        chk("t1_npush", plog.size(), 6);
        for (int i = 0; i < 6; i++) chk("t1_push_val", plog[i], wdata(16'(i)));
        chk("t1_req_end", bus.mem_req, 1'b0);
        chk("t1_pc_end", fetch_pc, 16'h0006);
        chk("t1_qcnt", bus.q_count, 3'd6);

        // 2: latency 5 with pops, outstanding reads bounded by 2
        do_reset();
        lat = 5;
        pop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (80) tick();
        chk("t2_max_out", max_out, 2);
        chk("t2_enough", plog.size() >= 8, 1'b1);
        for (int i = 0; i < plog.size(); i++) chk("t2_order", plog[i], wdata(16'(i)));

        // 3: redirect with two reads outstanding
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if ((nack - nrv) == 2 && !bus.mem_rvalid) found = 1'b1;
            else tick();
        end
        chk("t3_setup", found, 1'b1);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk("t3_flush", bus.q_flush, 1'b1);
        chk("t3_push_cancel", bus.q_push, 1'b0);
        chk("t3_req_off", bus.mem_req, 1'b0);
        chk("t3_pc", fetch_pc, 16'h0100);
        n0 = plog.size();
        for (int i = 0; i < 50 && plog.size() < n0 + 2; i++) tick();
        chk("t3_npush", plog.size() >= n0 + 2, 1'b1);
        chk("t3_first", plog[n0], wdata(16'h0100));
        chk("t3_second", plog[n0 + 1], wdata(16'h0101));
        chk("t3_nflush", nflush, 1);

        // 4: redirect in the same cycle as an ack and a response
        do_reset();
        pop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ack_en = 1'b0;
        chk("t4_req_a", bus.mem_req, 1'b1);
        tick();
        ack_en = 1'b1;
        chk("t4_req_b", bus.mem_req, 1'b1);
        chk("t4_addr_b", bus.mem_addr, 16'h0001);
        tick();
        chk("t4_ack_and_rv", bus.mem_rvalid && bus.mem_req && bus.mem_ack, 1'b1);
        redirect = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        chk("t4_flush", bus.q_flush, 1'b1);
        chk("t4_push0", bus.q_push, 1'b0);
        chk("t4_req0", bus.mem_req, 1'b0);
        chk("t4_addr0", bus.mem_addr, 16'h0200);
        tick();
        chk("t4_push1", bus.q_push, 1'b0);
        chk("t4_req1", bus.mem_req, 1'b0);
        chk("t4_flush1", bus.q_flush, 1'b0);
        tick();
        chk("t4_push2", bus.q_push, 1'b0);
        chk("t4_req2", bus.mem_req, 1'b0);
        tick();
        chk("t4_req3", bus.mem_req, 1'b1);
        chk("t4_addr3", bus.mem_addr, 16'h0200);
        chk("t4_no_stray", plog.size(), 0);
        repeat (10) tick();
        chk("t4_first", plog[0], wdata(16'h0200));
        chk("t4_nflush", nflush, 1);

        // 5: fetch PC wraps from FFFF to 0000
        do_reset();
        pop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        chk("t5_pc", fetch_pc, 16'hFFFF);
        chk("t5_req", bus.mem_req, 1'b0);
        tick();
        chk("t5_addr_ffff", bus.mem_addr, 16'hFFFF);
        tick();
        chk("t5_addr_wrap", bus.mem_addr, 16'h0000);
        chk("t5_pc_wrap", fetch_pc, 16'h0000);
        repeat (15) tick();
        chk("t5_push_ffff", plog[0], wdata(16'hFFFF));
        chk("t5_push_0000", plog[1], wdata(16'h0000));

        // 6: halt with reads in flight, then async reset mid-burst
        do_reset();
        lat = 5;
        pop_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        halt = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mem_req) req_seen++;
        end
        chk("t6_no_req", req_seen, 0);
        chk("t6_nack", nack, 2);
        chk("t6_npush", plog.size(), 2);
        chk("t6_push0", plog[0], wdata(16'h0000));
        chk("t6_push1", plog[1], wdata(16'h0001));
        halt = 1'b0;
        tick();
        chk("t6_resume", bus.mem_req, 1'b1);
        chk("t6_resume_addr", bus.mem_addr, 16'h0002);
        reset = 1'b1;
        #1;
        chk("t6_ar_req", bus.mem_req, 1'b0);
        chk("t6_ar_addr", bus.mem_addr, 16'h0000);
        chk("t6_ar_pc", fetch_pc, 16'h0000);
        chk("t6_ar_push", bus.q_push, 1'b0);
        chk("t6_ar_pval", bus.q_push_value, 16'h0000);
        chk("t6_ar_flush", bus.q_flush, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
